// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: FSM states, opcode fields,
// instruction classes and the ALU operation encoding.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_ALUWB,
        ST_MOVWB,
        ST_MEMRD,
        ST_LOADWB,
        ST_MEMWR
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_SHIFT,
        CLS_MOV,
        CLS_MOVI,
        CLS_LOAD,
        CLS_STOR,
        CLS_ILL
    } op_class_e;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_MEM   = 4'b0100;

    localparam logic [3:0] EXT_ADD  = 4'b0101;
    localparam logic [3:0] EXT_SUB  = 4'b1001;
    localparam logic [3:0] EXT_CMP  = 4'b1011;
    localparam logic [3:0] EXT_AND  = 4'b0001;
    localparam logic [3:0] EXT_OR   = 4'b0010;
    localparam logic [3:0] EXT_XOR  = 4'b0011;
    localparam logic [3:0] EXT_MOV  = 4'b1101;
    localparam logic [3:0] EXT_LSH  = 4'b0100;
    localparam logic [3:0] EXT_LOAD = 4'b0000;
    localparam logic [3:0] EXT_STOR = 4'b0100;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_CMP = 4'b0101;

    localparam logic [1:0] MUX4_REG = 2'b00;
    localparam logic [1:0] MUX4_IMM = 2'b01;
    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_MOV   = 2'b10;
    localparam logic [1:0] PC_REG   = 2'b00;

    // The same 4-bit code names an ALU op in Ext (R-type) or OpCode (I-type)
    function automatic logic is_alu_code(input logic [3:0] c);
        return (c == EXT_ADD) || (c == EXT_SUB) || (c == EXT_CMP) ||
               (c == EXT_AND) || (c == EXT_OR)  || (c == EXT_XOR);
    endfunction

    function automatic logic [3:0] alu_of(input logic [3:0] c);
        logic [3:0] a;
        a = ALU_ADD;
        case (c)
            EXT_SUB: a = ALU_SUB;
            EXT_CMP: a = ALU_CMP;
            EXT_AND: a = ALU_AND;
            EXT_OR:  a = ALU_OR;
            EXT_XOR: a = ALU_XOR;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/op_decode.sv
// Combinational instruction decode: class, ALU op, compare/LSHI
// flags and illegal detection from OpCode/OpCodeExt.
module op_decode
    import cpu_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic [3:0] ext_i,
    output op_class_e  cls_o,
    output logic [3:0] alu_o,
    output logic       cmp_o,
    output logic       lshi_o,
    output logic       illegal_o
);

    always_comb begin
        cls_o  = CLS_ILL;
        alu_o  = ALU_ADD;
        cmp_o  = 1'b0;
        lshi_o = 1'b0;
        unique case (op_i)
            OP_RTYPE: begin
                if (is_alu_code(ext_i)) begin
                    cls_o = CLS_R;
                    alu_o = alu_of(ext_i);
                    cmp_o = (ext_i == EXT_CMP);
                end else if (ext_i == EXT_MOV) begin
                    cls_o = CLS_MOV;
                end
            end
            OP_SHIFT: begin
                if (ext_i == EXT_LSH) begin
                    cls_o = CLS_SHIFT;
                end else if (ext_i[3:1] == 3'b000) begin
                    cls_o  = CLS_SHIFT;
                    lshi_o = 1'b1;
                end
            end
            OP_MOVI: cls_o = CLS_MOVI;
            OP_MEM: begin
                if (ext_i == EXT_LOAD) begin
                    cls_o = CLS_LOAD;
                end else if (ext_i == EXT_STOR) begin
                    cls_o = CLS_STOR;
                end
            end
            default: begin
                if (is_alu_code(op_i)) begin
                    cls_o = CLS_I;
                    alu_o = alu_of(op_i);
                    cmp_o = (op_i == EXT_CMP);
                end
            end
        endcase
    end

    assign illegal_o = (cls_o == CLS_ILL);

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle CPU control unit: sequences fetch, decode, execute,
// memory and writeback, driving datapath enables and selects.
module control_fsm
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] OpCode,
    input  logic [3:0] OpCodeExt,
    input  logic       memAck,
    output logic       memReq,
    output logic       memWrite,
    output logic       irS,
    output logic       srcRegEn,
    output logic       dstRegEn,
    output logic       immRegEn,
    output logic       resultRegEn,
    output logic       regFileEn,
    output logic       signEn,
    output logic       shiftALUMuxEn,
    output logic       regImmMuxEn,
    output logic [1:0] mux4En,
    output logic [1:0] regpcCont,
    output logic [1:0] exMemResultEn,
    output logic [3:0] aluControl,
    output logic       illegal
);

    state_e     state_q, state_d;
    op_class_e  cls;
    logic [3:0] alu_op;
    logic       is_cmp;
    logic       is_lshi;
    logic       is_ill;

    op_decode u_dec (
        .op_i      (OpCode),
        .ext_i     (OpCodeExt),
        .cls_o     (cls),
        .alu_o     (alu_op),
        .cmp_o     (is_cmp),
        .lshi_o    (is_lshi),
        .illegal_o (is_ill)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FETCH:  if (memAck) state_d = ST_DECODE;
            ST_DECODE: begin
                unique case (cls)
                    CLS_R, CLS_I, CLS_SHIFT: state_d = ST_EXEC;
                    CLS_MOV, CLS_MOVI:       state_d = ST_MOVWB;
                    CLS_LOAD:                state_d = ST_MEMRD;
                    CLS_STOR:                state_d = ST_MEMWR;
                    CLS_ILL:                 state_d = ST_FETCH;
                endcase
            end
            // Compares only update flags, so they skip writeback
            ST_EXEC:   state_d = is_cmp ? ST_FETCH : ST_ALUWB;
            ST_ALUWB:  state_d = ST_FETCH;
            ST_MOVWB:  state_d = ST_FETCH;
            ST_MEMRD:  if (memAck) state_d = ST_LOADWB;
            ST_LOADWB: state_d = ST_FETCH;
            ST_MEMWR:  if (memAck) state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are a function of state and opcode, blanked while in reset
    always_comb begin
        memReq        = 1'b0;
        memWrite      = 1'b0;
        irS           = 1'b0;
        srcRegEn      = 1'b0;
        dstRegEn      = 1'b0;
        immRegEn      = 1'b0;
        resultRegEn   = 1'b0;
        regFileEn     = 1'b0;
        signEn        = 1'b0;
        shiftALUMuxEn = 1'b0;
        regImmMuxEn   = 1'b0;
        mux4En        = MUX4_REG;
        regpcCont     = PC_REG;
        exMemResultEn = WB_ALU;
        aluControl    = ALU_ADD;
        illegal       = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ST_FETCH: begin
                    memReq = 1'b1;
                    irS    = 1'b1;
                end
                ST_DECODE: begin
                    if (is_ill) begin
                        illegal = 1'b1;
                    end else begin
                        srcRegEn = 1'b1;
                        dstRegEn = 1'b1;
                        immRegEn = 1'b1;
                    end
                end
                ST_EXEC: begin
                    resultRegEn = 1'b1;
                    aluControl  = alu_op;
                    if (cls == CLS_I) begin
                        mux4En = MUX4_IMM;
                        signEn = 1'b1;
                    end
                    if (cls == CLS_SHIFT) begin
                        shiftALUMuxEn = 1'b1;
                        regImmMuxEn   = is_lshi;
                    end
                end
                ST_ALUWB: begin
                    regFileEn     = 1'b1;
                    exMemResultEn = WB_ALU;
                end
                ST_MOVWB: begin
                    regFileEn     = 1'b1;
                    exMemResultEn = WB_MOV;
                    if (cls == CLS_MOVI) begin
                        mux4En = MUX4_IMM;
                        signEn = 1'b1;
                    end
                end
                ST_MEMRD: begin
                    memReq    = 1'b1;
                    regpcCont = PC_REG;
                end
                ST_LOADWB: begin
                    regFileEn     = 1'b1;
                    exMemResultEn = WB_MEM;
                end
                ST_MEMWR: begin
                    memReq    = 1'b1;
                    memWrite  = 1'b1;
                    regpcCont = PC_REG;
                end
            endcase
        end
    end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports OpCode, OpCodeExt, input, 4 each; fields from the instruction register.
REQ-004 SHALL have port memAck, input, 1; memory done, sampled each cycle of a memory state.
REQ-005 SHALL have port memReq, output, 1; memory access request.
REQ-006 SHALL have port memWrite, output, 1; 1 = store, 0 = read.
REQ-007 SHALL have port irS, output, 1; instruction register latch enable.
REQ-008 SHALL have ports srcRegEn, dstRegEn, immRegEn, resultRegEn, regFileEn, signEn, shiftALUMuxEn, regImmMuxEn, output, 1 each; datapath controls.
REQ-009 SHALL have ports mux4En, regpcCont, exMemResultEn, output, 2 each; datapath mux selects.
REQ-010 SHALL have port aluControl, output, 4; ALU operation.
REQ-011 SHALL have port illegal, output, 1; one-cycle pulse on an undecodable instruction.

Function
REQ-012 SHALL use states FETCH, DECODE, EXEC, ALUWB, MOVWB, MEMRD, LOADWB, MEMWR.
REQ-013 SHALL, in FETCH: memReq=1, memWrite=0, irS=1; hold FETCH until memAck=1, then go to DECODE.
REQ-014 SHALL, in DECODE: srcRegEn=dstRegEn=immRegEn=1 for exactly one cycle, then branch on the opcode class.
REQ-015 SHALL route opcode classes from DECODE as follows:
- R-type (OpCode 0000; Ext ADD 0101, SUB 1001, CMP 1011, AND 0001, OR 0010, XOR 0011) -> EXEC.
- I-type (same values in OpCode, Ext ignored) -> EXEC.
- Shift (OpCode 1000; Ext 0100 LSH, 000x LSHI) -> EXEC.
- MOV (0000/1101), MOVI (1101) -> MOVWB.
- LOAD (0100/0000) -> MEMRD.
- STOR (0100/0100) -> MEMWR.
- Any other encoding -> FETCH with illegal=1.
REQ-016 SHALL, in EXEC, assert resultRegEn=1 with these settings:
- R-type: mux4En=00.
- I-type: mux4En=01, signEn=1.
- Shift: shiftALUMuxEn=1; regImmMuxEn=1 only for LSHI.
- aluControl per the package encoding.
REQ-017 SHALL go EXEC -> ALUWB, except CMP/CMPI, which go EXEC -> FETCH (no writeback).
REQ-018 SHALL, in ALUWB: regFileEn=1, exMemResultEn=00, then go to FETCH.
REQ-019 SHALL, in MOVWB: regFileEn=1, exMemResultEn=10, mux4En=00 (MOV) or 01 with signEn=1 (MOVI), then go to FETCH.
REQ-020 SHALL, in MEMRD: memReq=1, memWrite=0, regpcCont=00; hold until memAck, then go to LOADWB.
REQ-021 SHALL, in LOADWB: regFileEn=1, exMemResultEn=01, then go to FETCH.
REQ-022 SHALL, in MEMWR: memReq=1, memWrite=1, regpcCont=00; hold until memAck, then go to FETCH.
REQ-023 SHALL drive every output not listed for the current state to 0; all outputs are combinational from state and opcode (Moore, plus opcode-dependent selects).
REQ-024 SHALL keep latency with memAck tied high at: R/I/shift 4 cycles, CMP 3, MOV/MOVI 3, LOAD 4, STOR 3.
REQ-025 SHALL keep regFileEn and memWrite from ever being asserted in the same cycle.

Reset
REQ-026 SHALL force state to FETCH and all outputs to 0 on the cycle reset is high, overriding memAck; a reset mid-access abandons the access.
REQ-027 SHALL leave FETCH outputs active from the first cycle after reset deasserts.

Structure
REQ-028 SHALL place the state enum, opcode/extension constants and the aluControl encoding (ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, CMP 0101) in shared package cpu_pkg.
REQ-029 SHALL contain one sub-module, op_decode: combinational opcode-to-class, aluControl and illegal decode.

Verification
REQ-030 SHALL verify ADD (OpCode 0000/0101), memAck=1: FETCH, DECODE, EXEC (resultRegEn=1, aluControl=0000, mux4En=00), ALUWB (regFileEn=1, exMemResultEn=00), FETCH.
REQ-031 SHALL verify LOAD with memAck low 3 cycles in MEMRD: memReq=1 held 3 cycles, then LOADWB with exMemResultEn=01, regFileEn=1.
REQ-032 SHALL verify CMPI (1011): EXEC with mux4En=01, signEn=1, then FETCH; regFileEn never 1.
REQ-033 SHALL verify opcode 1110: DECODE -> FETCH with a single-cycle illegal=1, and no enables asserted.
REQ-034 SHALL verify reset asserted during MEMWR with memAck=0: next cycle state FETCH, memReq=0, memWrite=0.
REQ-035 SHALL verify LSHI (1000/0000): EXEC with shiftALUMuxEn=1, regImmMuxEn=1, then ALUWB.
